// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states, default widths.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, trial-subtract/restore for divide.
// {i_acc, i_q} is the double-width working register; i_b is the multiplicand or divisor magnitude.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_trial;
    logic             w_ge;

    always_comb begin
        w_sum     = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : '0);
        w_shifted = {i_acc, i_q[WIDTH-1]};
        w_ge      = (w_shifted >= {1'b0, i_b});
        // When the trial succeeds the true difference is below 2^WIDTH, so the truncated subtract is exact.
        w_trial   = w_shifted[WIDTH-1:0] - i_b;
        if (i_is_div) begin
            o_acc = w_ge ? w_trial : w_shifted[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], w_ge};
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/DIV sequencer owning HI/LO; IDLE -> CALC (WIDTH cycles) -> FIXUP -> DONE.
// Build option MULDIV_DIVZERO_SKIP_EN: divide by zero jumps straight from IDLE to DONE.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           o_dbg_state
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_q;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_a_neg    = Sign & A[WIDTH-1];
    assign w_b_neg    = Sign & B[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -A : A;
    assign w_b_mag    = w_b_neg ? -B : B;
    assign w_prod_neg = -{r_acc, r_q};

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_q      (r_q),
        .i_b      (r_b),
        .o_acc    (w_step_acc),
        .o_q      (w_step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && (op == OP_MTHI)) begin
                        r_hi <= A;
                    end else if (start && (op == OP_MTLO)) begin
                        r_lo <= A;
                    end else if (start) begin
                        r_acc    <= '0;
                        r_q      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_is_div <= (op == OP_DIV);
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_state  <= CALC;
`ifdef MULDIV_DIVZERO_SKIP_EN
                        if ((op == OP_DIV) && (B == '0)) begin
                            r_acc   <= A;
                            r_q     <= '1;
                            r_busy  <= 1'b1;
                            r_state <= DONE;
                        end
`endif
                    end
                end
                CALC: begin
                    r_busy <= 1'b1;
                    r_acc  <= w_step_acc;
                    r_q    <= w_step_q;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= FIXUP;
                    end
                end
                FIXUP: begin
                    r_busy <= 1'b1;
                    if (r_is_div) begin
                        // A zero divisor leaves |A| as remainder; restoring the dividend sign yields A itself.
                        if (r_b == '0) begin
                            r_q <= '1;
                        end else if (r_neg_q) begin
                            r_q <= -r_q;
                        end
                        if (r_neg_r) begin
                            r_acc <= -r_acc;
                        end
                    end else if (r_neg_q) begin
                        {r_acc, r_q} <= w_prod_neg;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    r_hi    <= r_acc;
                    r_lo    <= r_q;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer sitting beside the single-cycle ALU in the MIPS datapath.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the HI/LO registers.
- Raises busy so the main control unit stalls MFHI/MFLO and any new mult/div until the result is written.
- Uses the same Sign convention as the ALU: Sign=1 means signed, Sign=0 means unsigned.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request from control; sampled only in IDLE.
- op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- Sign  in  1  1 = signed operation, 0 = unsigned.
- A  in  WIDTH  multiplicand/dividend (rs); the value source for MTHI/MTLO.
- B  in  WIDTH  multiplier/divisor (rt).
- busy  out  1  high from the cycle after MULT/DIV acceptance until done.
- done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; busy=0, done=0, hi=0, lo=0, counter=0. Reset asserted mid-operation aborts it; no partial result reaches HI/LO.
- States: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
- IDLE, start=1, op=MULT or DIV:
  - Latch |A| and |B| (magnitudes when Sign=1), plus the result signs.
  - Clear the accumulator, load counter=WIDTH, go to CALC.
- IDLE, start=1, op=MTHI/MTLO: write A to hi/lo at that edge. busy stays 0, done stays 0, state stays IDLE.
- CALC: one radix-2 step per cycle; counter decrements; leave for FIXUP when counter reaches 0. That is exactly WIDTH cycles.
  - MULT: shift-add; 2*WIDTH-bit product.
  - DIV: restoring division; quotient and remainder.
- FIXUP, 1 cycle, sign correction when Sign=1:
  - Product is negated if sign(A) xor sign(B).
  - Quotient is negated if sign(A) xor sign(B).
  - Remainder takes the sign of the dividend.
- DONE, 1 cycle:
  - MULT: hi=product[2W-1:W], lo=product[W-1:0].
  - DIV: lo=quotient, hi=remainder.
  - done=1; return to IDLE.
- Latency: acceptance at edge 0 gives CALC at edges 1..32, FIXUP at 33, done high in the cycle after edge 34. HI/LO are valid that same cycle. busy=1 from edge 1 until the DONE edge; busy=0 while done=1.
- start while not IDLE is ignored; the controller must not rely on queuing.
- Divide by zero, no trap:
  - Unsigned: lo=all ones, hi=A.
  - Signed: lo=all ones, hi=A.
- Signed overflow, A=0x80000000 / B=0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are captured at acceptance; A and B may change freely during CALC.

Optional Feature:
- Macro MULDIV_DIVZERO_SKIP_EN.
- Defined: DIV with B==0 skips CALC and FIXUP. It goes IDLE -> DONE, so done appears the cycle after edge 1 with the divide-by-zero result defined above. busy is high for 1 cycle only.
- Undefined: divide by zero runs the full 34-cycle sequence; the same result values are required.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_DIV, OP_MTHI, OP_MTLO;
  - state typedef {IDLE, CALC, FIXUP, DONE};
  - WIDTH default.
- One sub-module, muldiv_step: combinational single-iteration datapath (add/shift for MULT, trial subtract/restore for DIV). It is instantiated once; muldiv_seq holds all registers and the FSM.

Test Plan:
- MULT, Sign=0, A=0xFFFFFFFF, B=2 -> done at cycle 34; hi=0x00000001, lo=0xFFFFFFFE; busy high for cycles 1..33.
- MULT, Sign=1, A=0xFFFFFFFD (-3), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV, Sign=1, A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV, Sign=0, A=100, B=0 -> lo=0xFFFFFFFF, hi=100. done at cycle 34 without the macro; at cycle 1 with MULDIV_DIVZERO_SKIP_EN.
- MTHI with A=0x12345678, then MTLO with A=0x9ABCDEF0 on consecutive cycles -> hi and lo update the edge after each, busy stays 0. A start issued at cycle 10 of a DIV is ignored; the DIV result is unchanged.
- Signed DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. reset asserted at cycle 15 of a MULT -> next cycle busy=0, hi=lo=0, no done pulse; a new MULT then completes normally.
